alu_control_mc: RTL
===================

# alu_control_mc

Parametrised, multi-cycle successor to the EX-stage ALU control decoder. It decodes `alu_op`/`funct` into the single-cycle `alu_cnt` code, as before, and adds R-type unsigned multiply and divide. These run on an internal iterative engine, which stalls the pipeline until a 2×WIDTH result is ready in `hi`/`lo`. Sits in EX between the ID/EX register and the ALU/EX-MEM writeback mux.

## Interface
- `WIDTH`, 32: operand width; iteration count per mul/div.
- `OP_W`, 3: `alu_op` width.
- `FUNCT_W`, 6: `funct` width.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  EX holds a valid instruction.
- `flush`  in  1  synchronous abort of any in-flight mul/div.
- `alu_op`  in  OP_W  main-control ALU class.
- `funct`  in  FUNCT_W  R-type function field.
- `src_a`, `src_b`  in  WIDTH  operands (dividend/divisor for DIVU).
- `alu_cnt`  out  4  combinational ALU control code.
- `illegal`  out  1  combinational; undecodable op while `valid_in`.
- `md_op`  out  1  combinational; current instruction is MULU/DIVU.
- `stall`  out  1  combinational; freeze PC, IF/ID, ID/EX.
- `done`  out  1  registered; mul/div result valid this cycle.
- `hi`, `lo`  out  WIDTH  registered; MULU: product high/low; DIVU: remainder/quotient.
- `div_by_zero`  out  1  registered; qualifies `done` for DIVU with `src_b`=0.

## Operation
- Decode for `alu_op`=000: `funct`
  - 000000→0000 ADD; 000001→0001 SUB; 000010→0101 AND; 000011→0110 OR.
  - 000100→0111 SLT; 000101→0011 LSL; 000110→0100 LSR; 000111→0010 NOT.
  - 001000 MULU and 001001 DIVU → `alu_cnt`=0000 with `md_op`=1.
- Decode for other `alu_op` values: 001→0001 (BEQ); 010→0111 (SLTI); 011→0000 (ADDI/LW/SW).
- Any other `alu_op`/`funct` combination: `alu_cnt`=1111, `illegal`=`valid_in`. Never X.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE → MUL/DIV when `valid_in & md_op & !flush`. Operands latch, counter=WIDTH, accumulators clear.
- MUL: shift-add, one multiplier bit per cycle.
- DIV: restoring division, one quotient bit per cycle.
- Counter decrements each MUL/DIV cycle. At 0 → DONE, writing `hi`/`lo`.
- DONE: `done`=1 for exactly one cycle → IDLE. Pipeline advances on that edge.
- `stall` = `valid_in & md_op & (state != DONE)`. It is high in the IDLE cycle that issues the op.
- Divide by zero: runs the full WIDTH cycles. `lo`=all-ones, `hi`=`src_a`, `div_by_zero`=1 with `done`.
- `flush` in any state → IDLE next edge. No `done`; `hi`/`lo` hold previous values. `flush` beats start in IDLE.
- Operands are sampled only at start. Later `src_*` changes are ignored.
- Reset (async, any state): state IDLE, counter 0, `hi`=`lo`=0, `done`=0, `div_by_zero`=0.

## Timing
- Start sampled at edge E0. Iterations on edges E1..E_WIDTH.
- `done`, `hi`, `lo` valid in the cycle after E_WIDTH. IDLE at E_WIDTH+1.
- MUL/DIV latency: WIDTH+1 cycles of `stall`, plus one DONE cycle. WIDTH=32 gives 34 cycles total in EX.
- Back-to-back mul/div: the next op starts from IDLE in the cycle after DONE; no overlap.
- Non-md instructions: zero latency, `stall`=0.
- Width rules:
  - Product is 2×WIDTH, unsigned, no truncation.
  - Partial remainder is WIDTH+1 bits.
  - Counter is $clog2(WIDTH+1) bits.

## Structure
- `alu_pkg` holds the shared definitions:
  - `alu_op` class codes.
  - `funct` codes, including MULU/DIVU.
  - 4-bit `alu_cnt` codes.
  - FSM state enum.
  - The ALU uses the same `alu_cnt` encoding.
- Sub-module `alu_md_iter`: iterative mul/div datapath and counter.
  - Inputs: start, is_div, operands, flush.
  - Outputs: finish, 2×WIDTH result, div_by_zero.
  - The top level keeps the decode and the stall logic.

## Test plan
- Decode sweep: `alu_op`=000 with `funct`=000000..000111 → 0000,0001,0101,0110,0111,0011,0100,0010. `alu_op`=011 → 0000. `alu_op`=111 → 1111 with `illegal`=1.
- MULU FFFFFFFF×00000002 → `stall` high 33 cycles; then `done`=1, `hi`=00000001, `lo`=FFFFFFFE.
- DIVU 100÷7 → `lo`=14, `hi`=2, `div_by_zero`=0, `done` exactly one cycle.
- DIVU 5÷0 → `lo`=FFFFFFFF, `hi`=5, `div_by_zero`=1 with `done`.
- `flush` at iteration 10 of a MULU → IDLE next cycle, no `done`, `hi`/`lo` unchanged. A following MULU 3×4 gives `lo`=12.
- `rst_n` low mid-DIVU → all outputs 0 immediately. After release, DIVU 9÷3 gives `lo`=3, `hi`=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control definitions
//
// Purpose: alu_op class codes, R-type funct codes (including MULU/DIVU),
// the 4-bit alu_cnt encoding also consumed by the ALU, and the mul/div
// sequencer state enum.
// Ports: none (package).
package alu_pkg;

  // Main-control ALU classes
  localparam logic [2:0] ALU_OP_RTYPE  = 3'b000;
  localparam logic [2:0] ALU_OP_BRANCH = 3'b001;
  localparam logic [2:0] ALU_OP_SLTI   = 3'b010;
  localparam logic [2:0] ALU_OP_ADDI   = 3'b011;

  // R-type function field
  localparam logic [5:0] FUNCT_ADD  = 6'b000000;
  localparam logic [5:0] FUNCT_SUB  = 6'b000001;
  localparam logic [5:0] FUNCT_AND  = 6'b000010;
  localparam logic [5:0] FUNCT_OR   = 6'b000011;
  localparam logic [5:0] FUNCT_SLT  = 6'b000100;
  localparam logic [5:0] FUNCT_LSL  = 6'b000101;
  localparam logic [5:0] FUNCT_LSR  = 6'b000110;
  localparam logic [5:0] FUNCT_NOT  = 6'b000111;
  localparam logic [5:0] FUNCT_MULU = 6'b001000;
  localparam logic [5:0] FUNCT_DIVU = 6'b001001;

  // ALU control codes
  typedef enum logic [3:0] {
    CNT_ADD     = 4'b0000,
    CNT_SUB     = 4'b0001,
    CNT_NOT     = 4'b0010,
    CNT_LSL     = 4'b0011,
    CNT_LSR     = 4'b0100,
    CNT_AND     = 4'b0101,
    CNT_OR      = 4'b0110,
    CNT_SLT     = 4'b0111,
    CNT_ILLEGAL = 4'b1111
  } alu_cnt_e;

  // Mul/div sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/alu_md_iter.sv
// rtl/alu_md_iter.sv - iterative unsigned multiply / restoring divide engine
//
// Purpose: one multiplier bit or one quotient bit per cycle for WIDTH cycles.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        latch operands and begin (ignored while flush_i)
//   is_div_i       1 = DIVU, 0 = MULU (sampled with start_i)
//   flush_i        abort any in-flight operation
//   a_i, b_i       multiplicand/multiplier or dividend/divisor
//   finish_o       the current cycle performs the last iteration
//   result_o       {hi, lo} as produced by the last iteration (valid with finish_o)
//   div_by_zero_o  running operation is a DIVU with a zero divisor
module alu_md_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               is_div_i,
  input  logic               flush_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               finish_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               is_div_q, is_div_d;
  // multiply datapath
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  // divide datapath; the stored remainder is always below the divisor so it
  // fits WIDTH bits, only the shifted trial value needs WIDTH+1
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;

  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_sub;
  logic [WIDTH:0]     rem_step;
  logic               rem_ge;
  logic [WIDTH-1:0]   quo_step;

  // One iteration of each algorithm, evaluated every cycle
  always_comb begin
    prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    // dividend bits enter the remainder from the top of the quotient register
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, dvsr_q});
    rem_sub   = rem_shift - {1'b0, dvsr_q};
    rem_step  = rem_ge ? rem_sub : rem_shift;
    quo_step  = WIDTH'({quo_q, rem_ge});
  end

  always_comb begin
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    is_div_d = is_div_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    if (flush_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = CNT_W'(WIDTH);
      is_div_d = is_div_i;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      prod_d   = '0;
      rem_d    = '0;
      quo_d    = a_i;
      dvsr_d   = b_i;
    end else if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
      end
      if (is_div_q) begin
        // a zero divisor always "fits": quotient saturates to all-ones and the
        // dividend ends up shifted whole into the remainder
        rem_d = WIDTH'(rem_step);
        quo_d = quo_step;
      end else begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
    end
  end

  assign finish_o      = busy_q && (cnt_q == CNT_W'(1));
  assign result_o      = is_div_q ? {WIDTH'(rem_step), quo_step} : prod_step;
  assign div_by_zero_o = is_div_q && (dvsr_q == '0);

endmodule

// File: rtl/alu_control_mc.sv
// rtl/alu_control_mc.sv - EX-stage ALU control decoder with multi-cycle MULU/DIVU
//
// Purpose: decodes alu_op/funct into alu_cnt, sequences the iterative mul/div
// engine and stalls the pipeline until the 2*WIDTH result is in hi/lo.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_in          EX holds a valid instruction
//   flush             abort any in-flight mul/div
//   alu_op, funct     main-control class and R-type function field
//   src_a, src_b      operands (dividend/divisor for DIVU)
//   alu_cnt           combinational ALU control code
//   illegal           combinational, undecodable op while valid_in
//   md_op             combinational, instruction is MULU/DIVU
//   stall             combinational, freeze PC, IF/ID, ID/EX
//   done              registered one-cycle result strobe
//   hi, lo            registered product high/low or remainder/quotient
//   div_by_zero       registered, qualifies done for a zero-divisor DIVU
module alu_control_mc
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int OP_W    = 3,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic               flush,
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic [3:0]         alu_cnt,
  output logic               illegal,
  output logic               md_op,
  output logic               stall,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               div_by_zero
);

  alu_cnt_e           cnt_c;
  logic               legal_c;
  logic               md_op_c;
  logic               is_div_c;
  logic               md_start;
  logic               md_finish;
  logic [2*WIDTH-1:0] md_result;
  logic               md_dbz;

  md_state_e          state_q;
  logic               done_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Decode; every unlisted combination falls through to CNT_ILLEGAL
  always_comb begin
    cnt_c    = CNT_ILLEGAL;
    legal_c  = 1'b0;
    md_op_c  = 1'b0;
    is_div_c = 1'b0;
    if (alu_op == OP_W'(ALU_OP_RTYPE)) begin
      legal_c = 1'b1;
      case (funct)
        FUNCT_W'(FUNCT_ADD):  cnt_c = CNT_ADD;
        FUNCT_W'(FUNCT_SUB):  cnt_c = CNT_SUB;
        FUNCT_W'(FUNCT_AND):  cnt_c = CNT_AND;
        FUNCT_W'(FUNCT_OR):   cnt_c = CNT_OR;
        FUNCT_W'(FUNCT_SLT):  cnt_c = CNT_SLT;
        FUNCT_W'(FUNCT_LSL):  cnt_c = CNT_LSL;
        FUNCT_W'(FUNCT_LSR):  cnt_c = CNT_LSR;
        FUNCT_W'(FUNCT_NOT):  cnt_c = CNT_NOT;
        FUNCT_W'(FUNCT_MULU): begin
          cnt_c   = CNT_ADD;
          md_op_c = 1'b1;
        end
        FUNCT_W'(FUNCT_DIVU): begin
          cnt_c    = CNT_ADD;
          md_op_c  = 1'b1;
          is_div_c = 1'b1;
        end
        default: begin
          cnt_c   = CNT_ILLEGAL;
          legal_c = 1'b0;
        end
      endcase
    end else if (alu_op == OP_W'(ALU_OP_BRANCH)) begin
      cnt_c   = CNT_SUB;
      legal_c = 1'b1;
    end else if (alu_op == OP_W'(ALU_OP_SLTI)) begin
      cnt_c   = CNT_SLT;
      legal_c = 1'b1;
    end else if (alu_op == OP_W'(ALU_OP_ADDI)) begin
      cnt_c   = CNT_ADD;
      legal_c = 1'b1;
    end
  end

  assign alu_cnt = cnt_c;
  assign illegal = valid_in & ~legal_c;
  assign md_op   = md_op_c;
  // The issuing IDLE cycle already stalls; DONE releases so the pipeline
  // advances on the same edge that returns the sequencer to IDLE.
  assign stall   = valid_in & md_op_c & (state_q != ST_DONE);

  // flush beats start
  assign md_start = valid_in & md_op_c & ~flush & (state_q == ST_IDLE);

  alu_md_iter #(
    .WIDTH (WIDTH)
  ) u_md_iter (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (md_start),
    .is_div_i      (is_div_c),
    .flush_i       (flush),
    .a_i           (src_a),
    .b_i           (src_b),
    .finish_o      (md_finish),
    .result_o      (md_result),
    .div_by_zero_o (md_dbz)
  );

  // Sequencer; done/div_by_zero are one-cycle strobes, hi/lo hold until the
  // next completed operation (a flushed op leaves them untouched)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (flush) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (md_start) begin
              state_q <= is_div_c ? ST_DIV : ST_MUL;
            end
          end
          ST_MUL, ST_DIV: begin
            if (md_finish) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              dbz_q   <= md_dbz;
              hi_q    <= md_result[2*WIDTH-1:WIDTH];
              lo_q    <= md_result[WIDTH-1:0];
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
